// File: rtl/jesd204b_tx_link_seq.sv
// ---------------------------------------------------------------------------
// jesd204b_tx_link_seq
//
// Transmit link-layer sequencer for one JESD204B lane. It generates the
// octet/control-flag stream for the lane's 8B/10B encoder:
//   CGS  : continuous /K/ (K28.5) until the receiver releases SYNC~ and at
//          least CGS_MIN /K/ octets have gone out, then wait for an LMFC edge.
//   ILAS : ILAS_MF multiframes of /R/ ... /A/, with the link configuration
//          (/Q/ + 14 config octets) carried in the second multiframe.
//   DATA : user octets from the transport layer.
// A sustained SYNC~ low (SYNC_ERR_LEN synchronised cycles) in ILAS or DATA
// sends the link back to CGS; a shorter low is ignored and flagged.
//
// Ports
//   BYTECLK        in   octet clock (only clock of the block)
//   reset          in   asynchronous, active-high reset
//   sync_n         in   SYNC~ from the receiver, active-low, asynchronous
//   tx_data[7:0]   in   user octet, consumed on every edge while tx_ready=1
//   tx_ready       out  high while in DATA
//   ilas_cfg_addr  out  link-config octet index 0..13 (0 outside the window)
//   ilas_cfg_data  in   config octet for ilas_cfg_addr, same-cycle lookup
//   enc_data[7:0]  out  octet to the encoder
//   enc_k          out  control-character flag to the encoder
//   lmfc           out  one-cycle pulse while the octet counter is 0
//   link_state     out  0 = CGS, 1 = ILAS, 2 = DATA (FSM state, debug view)
//   sync_err       out  one-cycle pulse when a short SYNC~ low is ignored
//
// Handshake: tx_data has no valid; while tx_ready is high the block takes
// tx_data on every rising BYTECLK edge and presents it on enc_data one cycle
// later. tx_ready is never low while an octet is being consumed.
// ---------------------------------------------------------------------------
module jesd204b_tx_link_seq #(
    parameter int F            = 2,
    parameter int K            = 16,
    parameter int ILAS_MF      = 4,
    parameter int CGS_MIN      = 16,
    parameter int SYNC_ERR_LEN = 5
) (
    input  logic       BYTECLK,
    input  logic       reset,
    input  logic       sync_n,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic [3:0] ilas_cfg_addr,
    input  logic [7:0] ilas_cfg_data,
    output logic [7:0] enc_data,
    output logic       enc_k,
    output logic       lmfc,
    output logic [1:0] link_state,
    output logic       sync_err
);

    localparam int FK  = F * K;
    localparam int OCW = $clog2(FK);
    localparam int MCW = (ILAS_MF > 1) ? $clog2(ILAS_MF) : 1;
    localparam int CGW = $clog2(CGS_MIN + 1);
    localparam int ERW = $clog2(SYNC_ERR_LEN + 1);

    localparam logic [7:0] OCT_K = 8'hBC;  // K28.5
    localparam logic [7:0] OCT_R = 8'h1C;  // K28.0
    localparam logic [7:0] OCT_A = 8'h7C;  // K28.3
    localparam logic [7:0] OCT_Q = 8'h9C;  // K28.4

    typedef enum logic [1:0] {
        ST_CGS  = 2'd0,
        ST_ILAS = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    // SYNC~ synchroniser; both flops reset low so the link starts in a
    // requested-resync condition.
    logic           sync_meta_q;
    logic           sn_q;

    state_t         state_q, state_d;
    logic [OCW-1:0] oc_q, oc_d;
    logic [MCW-1:0] mc_q, mc_d;
    logic [CGW-1:0] cgs_cnt_q, cgs_cnt_d;
    logic [ERW-1:0] err_cnt_q, err_cnt_d;
    logic [7:0]     enc_data_q, enc_data_d;
    logic           enc_k_q, enc_k_d;
    logic           tx_ready_q;
    logic           lmfc_q;
    logic           sync_err_q, sync_err_d;
    logic [3:0]     cfg_addr_q, cfg_addr_d;
    logic           oc_last;

    always_comb begin
        oc_last    = (oc_q == OCW'(FK - 1));
        oc_d       = oc_last ? '0 : oc_q + OCW'(1);
        state_d    = state_q;
        mc_d       = mc_q;
        cgs_cnt_d  = cgs_cnt_q;
        err_cnt_d  = err_cnt_q;
        sync_err_d = 1'b0;
        enc_data_d = OCT_K;
        enc_k_d    = 1'b1;
        cfg_addr_d = 4'd0;

        case (state_q)
            ST_CGS: begin
                enc_data_d = OCT_K;
                enc_k_d    = 1'b1;
                err_cnt_d  = '0;
                if (cgs_cnt_q != CGW'(CGS_MIN))
                    cgs_cnt_d = cgs_cnt_q + CGW'(1);
                // Leave only on an LMFC boundary so ILAS is multiframe aligned.
                if (sn_q && (cgs_cnt_q == CGW'(CGS_MIN)) && (oc_d == '0)) begin
                    state_d = ST_ILAS;
                    mc_d    = '0;
                end
            end
            ST_ILAS: begin
                if (oc_q == '0) begin
                    enc_data_d = OCT_R;
                    enc_k_d    = 1'b1;
                end else if (oc_last) begin
                    enc_data_d = OCT_A;
                    enc_k_d    = 1'b1;
                end else if ((mc_q == MCW'(1)) && (oc_q == OCW'(1))) begin
                    enc_data_d = OCT_Q;
                    enc_k_d    = 1'b1;
                end else if ((mc_q == MCW'(1)) && (oc_q <= OCW'(15))) begin
                    // ilas_cfg_addr was registered as oc-2 for this cycle.
                    enc_data_d = ilas_cfg_data;
                    enc_k_d    = 1'b0;
                end else begin
                    enc_data_d = 8'(oc_q);
                    enc_k_d    = 1'b0;
                end
                if (oc_last) begin
                    if (mc_q == MCW'(ILAS_MF - 1))
                        state_d = ST_DATA;
                    else
                        mc_d = mc_q + MCW'(1);
                end
            end
            ST_DATA: begin
                enc_data_d = tx_data;
                enc_k_d    = 1'b0;
            end
            default: begin
                state_d = ST_CGS;
            end
        endcase

        // Resync supervision overrides any ILAS->DATA move decided above.
        if (state_q != ST_CGS) begin
            if (!sn_q) begin
                if (err_cnt_q == ERW'(SYNC_ERR_LEN - 1)) begin
                    state_d   = ST_CGS;
                    cgs_cnt_d = '0;
                    err_cnt_d = '0;
                end else begin
                    err_cnt_d = err_cnt_q + ERW'(1);
                end
            end else begin
                err_cnt_d  = '0;
                sync_err_d = (err_cnt_q != '0);
            end
        end

        // Address is registered one cycle ahead so the lookup result is
        // ready in the cycle the config octet is captured.
        if ((state_d == ST_ILAS) && (mc_d == MCW'(1)) &&
            (oc_d >= OCW'(2)) && (oc_d <= OCW'(15)))
            cfg_addr_d = 4'(oc_d - OCW'(2));
    end

    always_ff @(posedge BYTECLK or posedge reset) begin
        if (reset) begin
            sync_meta_q <= 1'b0;
            sn_q        <= 1'b0;
            state_q     <= ST_CGS;
            oc_q        <= '0;
            mc_q        <= '0;
            cgs_cnt_q   <= '0;
            err_cnt_q   <= '0;
            enc_data_q  <= OCT_K;
            enc_k_q     <= 1'b1;
            tx_ready_q  <= 1'b0;
            lmfc_q      <= 1'b0;
            sync_err_q  <= 1'b0;
            cfg_addr_q  <= 4'd0;
        end else begin
            sync_meta_q <= sync_n;
            sn_q        <= sync_meta_q;
            state_q     <= state_d;
            oc_q        <= oc_d;
            mc_q        <= mc_d;
            cgs_cnt_q   <= cgs_cnt_d;
            err_cnt_q   <= err_cnt_d;
            enc_data_q  <= enc_data_d;
            enc_k_q     <= enc_k_d;
            tx_ready_q  <= (state_d == ST_DATA);
            lmfc_q      <= (oc_d == '0);
            sync_err_q  <= sync_err_d;
            cfg_addr_q  <= cfg_addr_d;
        end
    end

    assign tx_ready      = tx_ready_q;
    assign ilas_cfg_addr = cfg_addr_q;
    assign enc_data      = enc_data_q;
    assign enc_k         = enc_k_q;
    assign lmfc          = lmfc_q;
    assign link_state    = state_q;
    assign sync_err      = sync_err_q;

endmodule

// File: tb/tb_jesd204b_tx_link_seq.sv
// ---------------------------------------------------------------------------
// Bench for jesd204b_tx_link_seq (F=2, K=16, ILAS_MF=4, CGS_MIN=16,
// SYNC_ERR_LEN=5). Cycle c counts rising edges since reset release; the
// expected output vector for cycle c describes the outputs just after edge c.
// Vector layout: {link_state[1:0], tx_ready, lmfc, sync_err, enc_k,
//                 enc_data[7:0], ilas_cfg_addr[3:0]}
// ---------------------------------------------------------------------------
module tb_jesd204b_tx_link_seq;

    localparam int FK = 32;
    localparam logic [17:0] RST_VEC = {2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hBC, 4'd0};

    // clock/reset
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sync_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready;
    logic [3:0] ilas_cfg_addr;
    logic [7:0] ilas_cfg_data;
    logic [7:0] enc_data;
    logic       enc_k;
    logic       lmfc;
    logic [1:0] link_state;
    logic       sync_err;

    always #5 clk = ~clk;

    // config table model: octet = 0xA0 + address
    assign ilas_cfg_data = 8'hA0 + {4'h0, ilas_cfg_addr};

    jesd204b_tx_link_seq dut (
        .BYTECLK       (clk),
        .reset         (reset),
        .sync_n        (sync_n),
        .tx_data       (tx_data),
        .tx_ready      (tx_ready),
        .ilas_cfg_addr (ilas_cfg_addr),
        .ilas_cfg_data (ilas_cfg_data),
        .enc_data      (enc_data),
        .enc_k         (enc_k),
        .lmfc          (lmfc),
        .link_state    (link_state),
        .sync_err      (sync_err)
    );

    logic [17:0] dut_vec;
    assign dut_vec = {link_state, tx_ready, lmfc, sync_err, enc_k, enc_data, ilas_cfg_addr};

    // scoreboard
    logic [17:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    string       phase = "init";

    task automatic check(input string nm, input logic [17:0] got, input logic [17:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h (state,rdy,lmfc,serr,k,data,addr)",
                     nm, cyc, got, exp);
        end
    endtask

    // monitor: every cycle the encoder receives an octet; compare it
    always @(negedge clk) begin
        if (exp_q.size() != 0)
            check(phase, dut_vec, exp_q.pop_front());
    end

    // ILAS octet {k, data} for position idx (0..127) from the start of ILAS
    function automatic logic [8:0] ilas_oct(input int idx);
        int o;
        int m;
        o = idx % FK;
        m = idx / FK;
        if (o == 0)                          return {1'b1, 8'h1C};
        if (o == FK - 1)                     return {1'b1, 8'h7C};
        if (m == 1 && o == 1)                return {1'b1, 8'h9C};
        if (m == 1 && o >= 2 && o <= 15)     return {1'b0, 8'(8'hA0 + o - 2)};
        return {1'b0, 8'(o)};
    endfunction

    // Expected vector for cycle c of an uninterrupted start-up where the
    // link_state first reads ILAS after edge s.
    function automatic logic [17:0] exp_start(input int c, input int s);
        logic [1:0] st;
        logic       rdy;
        logic       lm;
        logic [8:0] kd;
        logic [3:0] a;
        int         r;
        lm  = (c % FK == 0);
        a   = 4'd0;
        rdy = 1'b0;
        if (c < s) begin
            st = 2'd0; kd = {1'b1, 8'hBC};
        end else if (c == s) begin
            st = 2'd1; kd = {1'b1, 8'hBC};
        end else if (c <= s + 127) begin
            st = 2'd1;
            kd = ilas_oct(c - s - 1);
            r  = c - s;
            if ((r / FK == 1) && (r % FK >= 2) && (r % FK <= 15))
                a = 4'((r % FK) - 2);
        end else if (c == s + 128) begin
            st = 2'd2; rdy = 1'b1; kd = ilas_oct(127);
        end else begin
            st = 2'd2; rdy = 1'b1; kd = {1'b0, 8'(c - s - 129)};
        end
        return {st, rdy, lm, 1'b0, kd, a};
    endfunction

    // driver tasks
    task automatic tick(input logic sn_v, input logic [7:0] td_v, input logic [17:0] e);
        @(posedge clk);
        cyc++;
        exp_q.push_back(e);
        #1;
        sync_n  = sn_v;
        tx_data = td_v;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        sync_n  = 1'b0;
        tx_data = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc   = 0;
        #1;
        check("reset_state", dut_vec, RST_VEC);
    endtask

    initial begin
        logic [17:0] e;

        // 1: SYNC~ held low -> CGS forever, lmfc every 32 cycles
        phase = "cgs_hold";
        do_reset();
        for (int c = 1; c <= 100; c++)
            tick(1'b0, 8'h00, exp_start(c, 100000));

        // 2: SYNC~ rises after edge 40 -> sn high after edge 42, cgs_cnt long
        //    saturated, ILAS begins on the LMFC edge 64, DATA from edge 192.
        //    Then a 3-cycle glitch (ignored, sync_err at 206) and a 5-cycle
        //    low (CGS from edge 227).
        phase = "startup";
        do_reset();
        for (int c = 1; c <= 235; c++) begin
            logic       sv;
            logic [7:0] td;
            e  = exp_start(c, 64);
            if (c == 206) e[13] = 1'b1;
            if (c >= 227) e[17:15] = 3'b000;
            if (c >= 228) begin
                e[12:4] = {1'b1, 8'hBC};
                e[3:0]  = 4'd0;
            end
            sv = (c >= 40) && !(c >= 200 && c <= 202) && !(c >= 220 && c <= 224);
            td = (c >= 192) ? 8'(c - 192) : 8'h00;
            if (c >= 200) phase = "sync_glitch";
            if (c >= 220) phase = "resync";
            tick(sv, td, e);
        end

        // 3: early SYNC~ release -> ILAS from edge 32; reset in multiframe 2
        phase = "ilas_early";
        do_reset();
        for (int c = 1; c <= 100; c++)
            tick(c >= 10, 8'h00, exp_start(c, 32));
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        phase = "async_reset";
        check(phase, dut_vec, RST_VEC);

        // full CGS sequence again after reset
        phase = "restart";
        do_reset();
        for (int c = 1; c <= 70; c++)
            tick(c >= 10, 8'h00, exp_start(c, 32));

        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d entries left exp=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
